// File: rtl/panel_input.sv
// rtl/panel_input.sv - front-panel button/switch conditioner (optional macro PANEL_AUTOREPEAT_EN)

// Per-button debouncer: accepts a level change after DEBOUNCE_CYCLES stable cycles
module panel_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       din,
   output logic       req,
   output logic [1:0] phase
);
   typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;

   // state and counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // next-state: a full run of stable samples is needed to cross in either direction
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      req      = 1'b0;
      case (state)
         IDLE: begin
            if (din) begin
               state_nx = PRESS_WAIT;
               cnt_nx   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!din) begin
               state_nx = IDLE;
            end else if (cnt == LAST) begin
               state_nx = HELD;
               req      = 1'b1;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         HELD: begin
            if (!din) begin
               state_nx = RELEASE_WAIT;
               cnt_nx   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (din) begin
               state_nx = HELD;
            end else if (cnt == LAST) begin
               state_nx = IDLE;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign phase = state;
endmodule

module panel_input #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_next,
   input  logic       btn_run,
   input  logic       btn_speedrun,
   input  logic       btn_stop,
   input  logic [7:0] sw_value,
   input  logic       sw_mode,
   output logic       NEXT,
   output logic       RUN,
   output logic       SPEEDRUN,
   output logic       ENABLE,
   output logic [7:0] value,
   output logic       mode,
   output logic       busy
);
   // phase encodings exported by panel_debounce (its enum order)
   localparam logic [1:0] PH_IDLE = 2'd0;

   logic [12:0] raw, sync1, sync2;
   logic [3:0]  req;
   logic [1:0]  phase [4];
   logic        rpt_req;
   logic        next_req;

   assign raw = {sw_mode, sw_value, btn_stop, btn_speedrun, btn_run, btn_next};

   // two-flop synchroniser on every raw input
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   for (genvar i = 0; i < 4; i++) begin : g_btn
      panel_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W)
      ) u_deb (
         .clk  (clk),
         .rst  (rst),
         .din  (sync2[i]),
         .req  (req[i]),
         .phase(phase[i])
      );
   end

`ifdef PANEL_AUTOREPEAT_EN
   localparam logic [1:0]       PH_HELD     = 2'd2;
   localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

   logic [CNT_W-1:0] rpt_cnt;
   logic             rpt_first;
   logic             next_held;

   assign next_held = (phase[0] == PH_HELD);
   assign rpt_req   = next_held && (rpt_first ? (rpt_cnt == DELAY_LAST) : (rpt_cnt == PERIOD_LAST));

   // repeat timer: restarts whenever NEXT leaves HELD, long first gap then short period
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rpt_cnt   <= '0;
         rpt_first <= 1'b1;
      end else if (!next_held) begin
         rpt_cnt   <= '0;
         rpt_first <= 1'b1;
      end else if (rpt_req) begin
         rpt_cnt   <= '0;
         rpt_first <= 1'b0;
      end else begin
         rpt_cnt <= rpt_cnt + 1'b1;
      end
   end
`else
   assign rpt_req = 1'b0;
`endif

   assign next_req = req[0] | rpt_req;

   // priority arbitration into registered single-cycle pulses; losers are dropped
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         NEXT     <= 1'b0;
         RUN      <= 1'b0;
         SPEEDRUN <= 1'b0;
         ENABLE   <= 1'b0;
      end else begin
         NEXT     <= next_req;
         RUN      <= !next_req && req[1];
         SPEEDRUN <= !next_req && !req[1] && req[2];
         ENABLE   <= !next_req && !req[1] && !req[2] && req[3];
      end
   end

   // busy flag and switch snapshot, frozen while any button is in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy  <= 1'b0;
         value <= '0;
         mode  <= 1'b0;
      end else begin
         busy <= (phase[0] != PH_IDLE) || (phase[1] != PH_IDLE) ||
                 (phase[2] != PH_IDLE) || (phase[3] != PH_IDLE);
         if (!busy) begin
            value <= sync2[11:4];
            mode  <= sync2[12];
         end
      end
   end
endmodule

// File: tb/tb_panel_input.sv
// tb/tb_panel_input.sv - scoreboard bench for panel_input against a run-length model
module tb_panel_input;
   localparam int D  = 4;
   localparam int RD = 10;
   localparam int RP = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_next, btn_run, btn_speedrun, btn_stop;
   logic [7:0] sw_value;
   logic       sw_mode;
   logic       NEXT, RUN, SPEEDRUN, ENABLE;
   logic [7:0] value;
   logic       mode;
   logic       busy;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   panel_input #(
      .DEBOUNCE_CYCLES(D),
      .CNT_W          (8),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_next    (btn_next),
      .btn_run     (btn_run),
      .btn_speedrun(btn_speedrun),
      .btn_stop    (btn_stop),
      .sw_value    (sw_value),
      .sw_mode     (sw_mode),
      .NEXT        (NEXT),
      .RUN         (RUN),
      .SPEEDRUN    (SPEEDRUN),
      .ENABLE      (ENABLE),
      .value       (value),
      .mode        (mode),
      .busy        (busy)
   );

   typedef struct {
      int       cyc;
      bit [3:0] kind;
   } exp_t;
   exp_t q[$];

   // reference model: synced samples, debounced level + run length of opposite samples
   bit [3:0] s1b, s2b, deb;
   bit [7:0] s1v, s2v, val_m;
   bit       s1m, s2m, mode_m, busy_m, first;
   int       run [4];
   int       age, cyc;

   always @(posedge clk or posedge rst) begin : model
      bit [3:0] req, kind;
      bit       nonidle, held0, rep;
      if (rst) begin
         s1b = 0; s2b = 0; deb = 0; s1v = 0; s2v = 0; val_m = 0;
         s1m = 0; s2m = 0; mode_m = 0; busy_m = 0; first = 1; age = 0;
         for (int i = 0; i < 4; i++) run[i] = 0;
         q.delete();
      end else begin
         cyc++;
         nonidle = 0;
         for (int i = 0; i < 4; i++) if (deb[i] || run[i] != 0) nonidle = 1;
         held0 = deb[0] && run[0] == 0;
         req = 0;
         for (int i = 0; i < 4; i++) begin
            if (s2b[i] != deb[i]) begin
               run[i]++;
               if (run[i] == D + 1) begin
                  deb[i] = s2b[i];
                  run[i] = 0;
                  req[i] = s2b[i];
               end
            end else begin
               run[i] = 0;
            end
         end
         rep = 0;
`ifdef PANEL_AUTOREPEAT_EN
         if (!held0) begin
            age = 0; first = 1;
         end else begin
            age++;
            if (age == (first ? RD : RP)) begin
               rep = 1; age = 0; first = 0;
            end
         end
`endif
         if (!busy_m) begin
            val_m  = s2v;
            mode_m = s2m;
         end
         busy_m = nonidle;
         if (req[0] || rep)  kind = 4'b0001;
         else if (req[1])    kind = 4'b0010;
         else if (req[2])    kind = 4'b0100;
         else if (req[3])    kind = 4'b1000;
         else                kind = 4'b0000;
         if (kind != 0) q.push_back('{cyc, kind});
         s2b = s1b; s1b = {btn_stop, btn_speedrun, btn_run, btn_next};
         s2v = s1v; s1v = sw_value;
         s2m = s1m; s1m = sw_mode;
      end
   end

   // monitor: pops an expected pulse whenever the DUT or model presents one
   always @(negedge clk) begin : monitor
      bit [3:0] dutk, expk;
      dutk = {ENABLE, SPEEDRUN, RUN, NEXT};
      if (rst) begin
         vectors++;
         if (dutk != 0 || busy !== 1'b0 || value !== 8'h00 || mode !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state pulses=%b busy=%b value=%h mode=%b want all 0", dutk, busy, value, mode);
         end
      end else begin
         expk = 0;
         if (q.size() > 0 && q[0].cyc == cyc) expk = q.pop_front().kind;
         if (dutk != 0 || expk != 0) begin
            vectors++;
            if (dutk !== expk) begin
               miscompares++;
               $display("FAIL pulse cyc=%0d got=%b want=%b", cyc, dutk, expk);
            end
         end
         vectors++;
         if (busy !== busy_m || value !== val_m || mode !== mode_m) begin
            miscompares++;
            $display("FAIL status cyc=%0d busy=%b/%b value=%h/%h mode=%b/%b (got/want)",
                     cyc, busy, busy_m, value, val_m, mode, mode_m);
         end
      end
   end

   task automatic drive(input bit [3:0] b, input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #2;
         {btn_stop, btn_speedrun, btn_run, btn_next} = b;
      end
   endtask

   task automatic pulse_rst(input int n);
      @(posedge clk); #2; rst = 1'b1;
      repeat (n) @(posedge clk);
      #2; rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      {btn_stop, btn_speedrun, btn_run, btn_next} = 4'b0;
      sw_value = 8'h00; sw_mode = 1'b0;
      repeat (3) @(posedge clk);
      #2; rst = 1'b0;
      drive(4'b0000, 5);
      @(posedge clk); #2; sw_value = 8'hA5; sw_mode = 1'b1;
      drive(4'b0000, 6);

      // clean press with direct latency check; switches change mid-debounce
      @(posedge clk); #2; btn_next = 1'b1;
      for (int e = 0; e <= 6; e++) begin
         @(posedge clk); #1;
         if (e == 3) sw_value = 8'h3C;
         if (e == 5 || e == 6) begin
            vectors++;
            if (NEXT !== (e == 6)) begin
               miscompares++;
               $display("FAIL press_latency edge=%0d NEXT=%b want=%b", e, NEXT, (e == 6));
            end
         end
      end
      drive(4'b0001, 13);
      drive(4'b0000, 20);

      // bounce on press and release of RUN
      drive(4'b0010, 1); drive(4'b0000, 1); drive(4'b0010, 1); drive(4'b0000, 1);
      drive(4'b0010, 15);
      drive(4'b0000, 2); drive(4'b0010, 2); drive(4'b0000, 20);

      // simultaneous NEXT and STOP
      drive(4'b1001, 15); drive(4'b0000, 20);

      // reset in the middle of a SPEEDRUN debounce, button kept held
      drive(4'b0100, 3); pulse_rst(2); drive(4'b0100, 15); drive(4'b0000, 20);

      // long hold for auto-repeat
      drive(4'b0001, 40); drive(4'b0000, 20);

      // randomized segments
      for (int s = 0; s < 300; s++) begin
         if ($urandom_range(0, 39) == 0) pulse_rst($urandom_range(1, 2));
         if ($urandom_range(0, 3) == 0) begin
            sw_value = 8'($urandom); sw_mode = 1'($urandom);
         end
         drive(4'($urandom & $urandom), $urandom_range(1, 12));
      end
      drive(4'b0000, 30);

      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL leftover_pulses got=%0d want=0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
